// File: rtl/asrv32_trap_ctrl_pkg.sv
// Shared definitions for the ASRV32 trap sequencer: mcause codes, FSM state
// encoding and the priority-encoder result type.
package asrv32_trap_ctrl_pkg;

    localparam logic [3:0] CAUSE_INST_MISALIGNED  = 4'd0;
    localparam logic [3:0] CAUSE_ILLEGAL_INST     = 4'd2;
    localparam logic [3:0] CAUSE_BREAKPOINT       = 4'd3;
    localparam logic [3:0] CAUSE_LOAD_MISALIGNED  = 4'd4;
    localparam logic [3:0] CAUSE_STORE_MISALIGNED = 4'd6;
    localparam logic [3:0] CAUSE_ECALL_M          = 4'd11;

    localparam logic [3:0] CAUSE_MSI = 4'd3;
    localparam logic [3:0] CAUSE_MTI = 4'd7;
    localparam logic [3:0] CAUSE_MEI = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SAVE  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_RET   = 2'd3
    } trap_state_e;

    typedef enum logic [1:0] {
        MTVAL_ZERO = 2'd0,
        MTVAL_ADDR = 2'd1,
        MTVAL_INST = 2'd2
    } mtval_sel_e;

    typedef struct packed {
        logic       valid;
        logic       is_int;
        logic [3:0] code;
        mtval_sel_e mtval_sel;
    } trap_req_t;

endpackage

// File: rtl/asrv32_trap_ctrl_prio.sv
// Combinational cause selection: exceptions by fixed priority, then enabled
// and pending interrupts.
module asrv32_trap_prio
    import asrv32_trap_ctrl_pkg::*;
(
    input  logic       i_is_inst_illegal,
    input  logic       i_is_ecall,
    input  logic       i_is_ebreak,
    input  logic       i_inst_misaligned,
    input  logic       i_load_misaligned,
    input  logic       i_store_misaligned,
    input  logic       i_mstatus_mie,
    input  logic [2:0] i_mie,
    input  logic [2:0] i_mip,
    output trap_req_t  o_req
);

    logic [2:0] pending;

    // Bit order of mie/mip is {external, timer, software}.
    assign pending = {3{i_mstatus_mie}} & i_mie & i_mip;

    always_comb begin
        o_req = '{valid: 1'b0, is_int: 1'b0, code: 4'd0, mtval_sel: MTVAL_ZERO};
        if (i_is_ebreak) begin
            o_req = '{valid: 1'b1, is_int: 1'b0, code: CAUSE_BREAKPOINT, mtval_sel: MTVAL_ZERO};
        end else if (i_inst_misaligned) begin
            o_req = '{valid: 1'b1, is_int: 1'b0, code: CAUSE_INST_MISALIGNED, mtval_sel: MTVAL_ADDR};
        end else if (i_is_inst_illegal) begin
            o_req = '{valid: 1'b1, is_int: 1'b0, code: CAUSE_ILLEGAL_INST, mtval_sel: MTVAL_INST};
        end else if (i_is_ecall) begin
            o_req = '{valid: 1'b1, is_int: 1'b0, code: CAUSE_ECALL_M, mtval_sel: MTVAL_ZERO};
        end else if (i_load_misaligned) begin
            o_req = '{valid: 1'b1, is_int: 1'b0, code: CAUSE_LOAD_MISALIGNED, mtval_sel: MTVAL_ADDR};
        end else if (i_store_misaligned) begin
            o_req = '{valid: 1'b1, is_int: 1'b0, code: CAUSE_STORE_MISALIGNED, mtval_sel: MTVAL_ADDR};
        end else if (pending[2]) begin
            o_req = '{valid: 1'b1, is_int: 1'b1, code: CAUSE_MEI, mtval_sel: MTVAL_ZERO};
        end else if (pending[0]) begin
            o_req = '{valid: 1'b1, is_int: 1'b1, code: CAUSE_MSI, mtval_sel: MTVAL_ZERO};
        end else if (pending[1]) begin
            o_req = '{valid: 1'b1, is_int: 1'b1, code: CAUSE_MTI, mtval_sel: MTVAL_ZERO};
        end
    end

endmodule

// File: rtl/asrv32_trap_ctrl.sv
// ASRV32 trap sequencer: latches the winning cause in MEMORYACCESS and runs
// the SAVE/FLUSH or RET handshake with the CSR file while stalling the pipe.
module asrv32_trap_ctrl
    import asrv32_trap_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_stage_en,
    input  logic        i_is_inst_illegal,
    input  logic        i_is_ecall,
    input  logic        i_is_ebreak,
    input  logic        i_is_mret,
    input  logic        i_inst_misaligned,
    input  logic        i_load_misaligned,
    input  logic        i_store_misaligned,
    input  logic        i_mstatus_mie,
    input  logic [2:0]  i_mie,
    input  logic [2:0]  i_mip,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_alu_result,
    input  logic [31:0] i_inst,
    output logic        o_busy,
    output logic        o_trap_save,
    output logic        o_trap_restore,
    output logic [31:0] o_mepc,
    output logic [31:0] o_mtval,
    output logic        o_mcause_int,
    output logic [3:0]  o_mcause_code,
    output logic        o_go_to_trap_q,
    output logic        o_return_from_trap_q
);

    trap_state_e state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mtval_q, mtval_d;
    logic        int_q, int_d;
    logic [3:0]  code_q, code_d;

    trap_req_t   req;
    logic [31:0] mtval_new;

    asrv32_trap_prio u_prio (
        .i_is_inst_illegal (i_is_inst_illegal),
        .i_is_ecall        (i_is_ecall),
        .i_is_ebreak       (i_is_ebreak),
        .i_inst_misaligned (i_inst_misaligned),
        .i_load_misaligned (i_load_misaligned),
        .i_store_misaligned(i_store_misaligned),
        .i_mstatus_mie     (i_mstatus_mie),
        .i_mie             (i_mie),
        .i_mip             (i_mip),
        .o_req             (req)
    );

    always_comb begin
        mtval_new = 32'd0;
        case (req.mtval_sel)
            MTVAL_ADDR: mtval_new = i_alu_result;
            MTVAL_INST: mtval_new = i_inst;
            default:    mtval_new = 32'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mepc_d  = mepc_q;
        mtval_d = mtval_q;
        int_d   = int_q;
        code_d  = code_q;
        case (state_q)
            ST_IDLE: begin
                if (i_stage_en) begin
                    if (req.valid) begin
                        state_d = ST_SAVE;
                        mepc_d  = i_pc;
                        mtval_d = mtval_new;
                        int_d   = req.is_int;
                        code_d  = req.code;
                    end else if (i_is_mret) begin
                        state_d = ST_RET;
                    end
                end
            end
            ST_SAVE: begin
                state_d = ST_FLUSH;
                cnt_d   = 4'(FLUSH_CYCLES);
            end
            ST_FLUSH: begin
                cnt_d = cnt_q - 4'd1;
                // <= also catches a zero count so the FSM can never stick here.
                if (cnt_q <= 4'd1) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end
            end
            ST_RET: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            mepc_q  <= 32'd0;
            mtval_q <= 32'd0;
            int_q   <= 1'b0;
            code_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mepc_q  <= mepc_d;
            mtval_q <= mtval_d;
            int_q   <= int_d;
            code_q  <= code_d;
        end
    end

    assign o_busy               = (state_q != ST_IDLE);
    assign o_trap_save          = (state_q == ST_SAVE);
    assign o_go_to_trap_q       = (state_q == ST_SAVE);
    assign o_trap_restore       = (state_q == ST_RET);
    assign o_return_from_trap_q = (state_q == ST_RET);
    assign o_mepc               = mepc_q;
    assign o_mtval              = mtval_q;
    assign o_mcause_int         = int_q;
    assign o_mcause_code        = code_q;

endmodule

// File: tb/tb_asrv32_trap_ctrl.sv
// Directed bench for asrv32_trap_ctrl; two instances (FLUSH_CYCLES 1 and 4)
// share one stimulus bus.
module tb_asrv32_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stage_en, illegal, ecall, ebreak, mret;
    logic        inst_mis, load_mis, store_mis;
    logic        mstatus_mie;
    logic [2:0]  mie, mip;
    logic [31:0] pc, alu, inst;

    logic        busy1, save1, restore1, int1, goto1, ret1;
    logic [31:0] mepc1, mtval1;
    logic [3:0]  code1;
    logic        busy4, save4, restore4, int4, goto4, ret4;
    logic [31:0] mepc4, mtval4;
    logic [3:0]  code4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    asrv32_trap_ctrl #(.FLUSH_CYCLES(1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_stage_en(stage_en),
        .i_is_inst_illegal(illegal), .i_is_ecall(ecall), .i_is_ebreak(ebreak),
        .i_is_mret(mret), .i_inst_misaligned(inst_mis),
        .i_load_misaligned(load_mis), .i_store_misaligned(store_mis),
        .i_mstatus_mie(mstatus_mie), .i_mie(mie), .i_mip(mip),
        .i_pc(pc), .i_alu_result(alu), .i_inst(inst),
        .o_busy(busy1), .o_trap_save(save1), .o_trap_restore(restore1),
        .o_mepc(mepc1), .o_mtval(mtval1), .o_mcause_int(int1),
        .o_mcause_code(code1), .o_go_to_trap_q(goto1),
        .o_return_from_trap_q(ret1)
    );

    asrv32_trap_ctrl #(.FLUSH_CYCLES(4)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_stage_en(stage_en),
        .i_is_inst_illegal(illegal), .i_is_ecall(ecall), .i_is_ebreak(ebreak),
        .i_is_mret(mret), .i_inst_misaligned(inst_mis),
        .i_load_misaligned(load_mis), .i_store_misaligned(store_mis),
        .i_mstatus_mie(mstatus_mie), .i_mie(mie), .i_mip(mip),
        .i_pc(pc), .i_alu_result(alu), .i_inst(inst),
        .o_busy(busy4), .o_trap_save(save4), .o_trap_restore(restore4),
        .o_mepc(mepc4), .o_mtval(mtval4), .o_mcause_int(int4),
        .o_mcause_code(code4), .o_go_to_trap_q(goto4),
        .o_return_from_trap_q(ret4)
    );

    task automatic clear_inputs();
        stage_en = 0; illegal = 0; ecall = 0; ebreak = 0; mret = 0;
        inst_mis = 0; load_mis = 0; store_mis = 0;
        mstatus_mie = 0; mie = 3'b000; mip = 3'b000;
        pc = 32'd0; alu = 32'd0; inst = 32'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        clear_inputs();
        repeat (8) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        tick();
        tick();
        checks++;
        if ({busy1, save1, restore1, goto1, ret1, int1, code1} !== 10'd0) begin
            errors++;
            $display("FAIL reset_ctrl1: got %b required 0", {busy1, save1, restore1, goto1, ret1, int1, code1});
        end
        checks++;
        if ({mepc1, mtval1} !== 64'd0) begin
            errors++;
            $display("FAIL reset_data1: mepc=%h mtval=%h required 0", mepc1, mtval1);
        end
        checks++;
        if ({busy4, save4, restore4, goto4, ret4, int4, code4, mepc4, mtval4} !== 74'd0) begin
            errors++;
            $display("FAIL reset_dut4: busy=%b mepc=%h mtval=%h required 0", busy4, mepc4, mtval4);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_illegal();
        int nb1, nb4, ns1;
        stage_en = 1; illegal = 1; pc = 32'h100; inst = 32'hFFFF_FFFF;
        tick();
        clear_inputs();
        checks++;
        if ({save1, goto1, busy1, restore1} !== 4'b1110) begin
            errors++;
            $display("FAIL illegal_save: save/goto/busy/restore=%b required 1110", {save1, goto1, busy1, restore1});
        end
        checks++;
        if ({int1, code1} !== 5'b0_0010) begin
            errors++;
            $display("FAIL illegal_cause: int=%b code=%0d required int=0 code=2", int1, code1);
        end
        checks++;
        if (mepc1 !== 32'h100 || mtval1 !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL illegal_vals: mepc=%h mtval=%h required 00000100 ffffffff", mepc1, mtval1);
        end
        nb1 = int'(busy1); nb4 = int'(busy4); ns1 = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            nb1 += int'(busy1);
            nb4 += int'(busy4);
            ns1 += int'(save1);
        end
        checks++;
        if (nb1 != 2 || ns1 != 0) begin
            errors++;
            $display("FAIL illegal_busy1: busy cycles=%0d extra saves=%0d required 2 and 0", nb1, ns1);
        end
        checks++;
        if (nb4 != 5) begin
            errors++;
            $display("FAIL illegal_busy4: busy cycles=%0d required 5", nb4);
        end
        checks++;
        if (mepc1 !== 32'h100 || mtval1 !== 32'hFFFF_FFFF || code1 !== 4'd2) begin
            errors++;
            $display("FAIL illegal_hold: mepc=%h mtval=%h code=%0d required held values", mepc1, mtval1, code1);
        end
    endtask

    task automatic test_exc_priority();
        // {illegal, ecall, ebreak, inst_mis, load_mis, store_mis}
        logic [5:0]  flags [6] = '{6'b010010, 6'b000010, 6'b000001, 6'b100100, 6'b110000, 6'b111111};
        logic [3:0]  exp_code [6] = '{4'd11, 4'd4, 4'd6, 4'd0, 4'd2, 4'd3};
        logic [31:0] exp_tval [6] = '{32'h0, 32'h203, 32'h203, 32'h203, 32'hDEAD_BEEF, 32'h0};
        for (int i = 0; i < 6; i++) begin
            stage_en = 1;
            {illegal, ecall, ebreak, inst_mis, load_mis, store_mis} = flags[i];
            alu = 32'h203; inst = 32'hDEAD_BEEF; pc = 32'h200 + 32'(i * 4);
            tick();
            clear_inputs();
            checks++;
            if (save1 !== 1'b1 || int1 !== 1'b0 || code1 !== exp_code[i]) begin
                errors++;
                $display("FAIL exc_cause[%0d]: save=%b int=%b code=%0d required 1 0 %0d", i, save1, int1, code1, exp_code[i]);
            end
            checks++;
            if (mtval1 !== exp_tval[i] || mepc4 !== 32'h200 + 32'(i * 4)) begin
                errors++;
                $display("FAIL exc_vals[%0d]: mtval=%h mepc4=%h required %h %h", i, mtval1, mepc4, exp_tval[i], 32'h200 + 32'(i * 4));
            end
            settle();
        end
    endtask

    task automatic test_interrupt();
        logic [2:0] en [3] = '{3'b111, 3'b011, 3'b010};
        logic [3:0] exp_code [3] = '{4'd11, 4'd3, 4'd7};
        for (int i = 0; i < 3; i++) begin
            stage_en = 1; mstatus_mie = 1; mie = en[i]; mip = 3'b111;
            pc = 32'h400 + 32'(i * 4);
            tick();
            clear_inputs();
            checks++;
            if (save1 !== 1'b1 || int1 !== 1'b1 || code1 !== exp_code[i]) begin
                errors++;
                $display("FAIL irq_cause[%0d]: save=%b int=%b code=%0d required 1 1 %0d", i, save1, int1, code1, exp_code[i]);
            end
            checks++;
            if (mtval1 !== 32'h0 || mepc1 !== 32'h400 + 32'(i * 4)) begin
                errors++;
                $display("FAIL irq_vals[%0d]: mtval=%h mepc=%h required 0 %h", i, mtval1, mepc1, 32'h400 + 32'(i * 4));
            end
            settle();
        end
        stage_en = 1; mstatus_mie = 0; mie = 3'b111; mip = 3'b111;
        tick();
        checks++;
        if (busy1 !== 1'b0 || busy4 !== 1'b0) begin
            errors++;
            $display("FAIL irq_gated_mie: busy1=%b busy4=%b required 0", busy1, busy4);
        end
        mstatus_mie = 1; mie = 3'b000;
        tick();
        checks++;
        if (busy1 !== 1'b0) begin
            errors++;
            $display("FAIL irq_gated_mask: busy=%b required 0", busy1);
        end
        stage_en = 0; mie = 3'b111; illegal = 1;
        tick();
        tick();
        checks++;
        if (busy1 !== 1'b0 || busy4 !== 1'b0) begin
            errors++;
            $display("FAIL stage_en_gate: busy1=%b busy4=%b required 0", busy1, busy4);
        end
        settle();
    endtask

    task automatic test_exc_vs_int();
        stage_en = 1; ebreak = 1; mstatus_mie = 1; mie = 3'b010; mip = 3'b010;
        pc = 32'h480;
        tick();
        clear_inputs();
        checks++;
        if (save1 !== 1'b1 || {int1, code1} !== 5'b0_0011) begin
            errors++;
            $display("FAIL exc_vs_int: save=%b int=%b code=%0d required 1 0 3", save1, int1, code1);
        end
        settle();
    endtask

    task automatic test_mret();
        stage_en = 1; mret = 1;
        tick();
        checks++;
        if ({restore1, ret1, busy1, save1, goto1} !== 5'b11100) begin
            errors++;
            $display("FAIL mret_ret: restore/ret/busy/save/goto=%b required 11100", {restore1, ret1, busy1, save1, goto1});
        end
        illegal = 1;
        tick();
        clear_inputs();
        checks++;
        if ({restore1, ret1, busy1, save1, busy4} !== 5'b00000) begin
            errors++;
            $display("FAIL mret_one_cycle: restore/ret/busy/save/busy4=%b required 00000", {restore1, ret1, busy1, save1, busy4});
        end
        tick();
        checks++;
        if (busy1 !== 1'b0 || save1 !== 1'b0) begin
            errors++;
            $display("FAIL mret_ignored_req: busy=%b save=%b required 0 0", busy1, save1);
        end
        stage_en = 1; mret = 1; mstatus_mie = 1; mie = 3'b001; mip = 3'b001; pc = 32'h4C0;
        tick();
        clear_inputs();
        checks++;
        if ({save1, restore1, int1, code1} !== 7'b10_1_0011 || mepc1 !== 32'h4C0) begin
            errors++;
            $display("FAIL mret_vs_irq: save=%b restore=%b int=%b code=%0d mepc=%h required 1 0 1 3 000004c0", save1, restore1, int1, code1, mepc1);
        end
        settle();
    endtask

    task automatic test_mid_reset();
        int nb4;
        stage_en = 1; illegal = 1; pc = 32'h500; inst = 32'hAAAA_5555;
        tick();
        clear_inputs();
        tick();
        tick();
        checks++;
        if (busy4 !== 1'b1 || save4 !== 1'b0) begin
            errors++;
            $display("FAIL midrst_pre: busy4=%b save4=%b required 1 0", busy4, save4);
        end
        rst_n = 0;
        tick();
        checks++;
        if ({busy4, save4, restore4, goto4, ret4, int4, code4} !== 10'd0 || mepc4 !== 32'd0 || mtval4 !== 32'd0) begin
            errors++;
            $display("FAIL midrst_clear: busy=%b code=%0d mepc=%h mtval=%h required all 0", busy4, code4, mepc4, mtval4);
        end
        rst_n = 1;
        tick();
        stage_en = 1; illegal = 1; pc = 32'h600; inst = 32'h1234_5678;
        tick();
        clear_inputs();
        checks++;
        if (save4 !== 1'b1 || code4 !== 4'd2 || mepc4 !== 32'h600 || mtval4 !== 32'h1234_5678) begin
            errors++;
            $display("FAIL midrst_retrap: save=%b code=%0d mepc=%h mtval=%h required 1 2 00000600 12345678", save4, code4, mepc4, mtval4);
        end
        nb4 = int'(busy4);
        for (int i = 0; i < 8; i++) begin
            tick();
            nb4 += int'(busy4);
        end
        checks++;
        if (nb4 != 5) begin
            errors++;
            $display("FAIL midrst_busy: busy cycles=%0d required 5", nb4);
        end
        settle();
    endtask

    task automatic test_back_to_back();
        int ns1, ns4;
        ns1 = 0; ns4 = 0;
        stage_en = 1; illegal = 1; pc = 32'h700; inst = 32'h0000_0013;
        for (int i = 0; i < 8; i++) begin
            tick();
            ns1 += int'(save1);
            ns4 += int'(save4);
        end
        clear_inputs();
        checks++;
        if (ns1 != 3) begin
            errors++;
            $display("FAIL b2b_saves1: saves=%0d required 3", ns1);
        end
        checks++;
        if (ns4 != 2) begin
            errors++;
            $display("FAIL b2b_saves4: saves=%0d required 2", ns4);
        end
        settle();
        checks++;
        if (busy1 !== 1'b0 || busy4 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: busy1=%b busy4=%b required 0", busy1, busy4);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_illegal();
        test_exc_priority();
        test_interrupt();
        test_exc_vs_int();
        test_mret();
        test_mid_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
